// File: rtl/vga_scan_engine.sv
// VGA raster scanner with two selectable timing sets, frame-boundary mode switching
// and a latency-matched flag pipeline that aligns syncs with renderer data.
package vga_pkg;
  typedef struct packed {
    logic [15:0] h_vis;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_vis;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        h_sync_active_low;
    logic        v_sync_active_low;
  } vga_params_t;

  localparam vga_params_t VGA_640X480_60 = '{
    h_vis: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_vis: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
    h_sync_active_low: 1'b1, v_sync_active_low: 1'b1
  };
endpackage

module vga_scan_engine #(
  parameter vga_pkg::vga_params_t params     = vga_pkg::VGA_640X480_60,
  parameter vga_pkg::vga_params_t params_alt = params,
  parameter int COLOR_BITS = 12,
  parameter int LATENCY    = 2,
  localparam int H_VIS_MAX = (int'(params.h_vis) > int'(params_alt.h_vis)) ?
                             int'(params.h_vis) : int'(params_alt.h_vis),
  localparam int V_VIS_MAX = (int'(params.v_vis) > int'(params_alt.v_vis)) ?
                             int'(params.v_vis) : int'(params_alt.v_vis),
  localparam int X_BITS = (H_VIS_MAX > 1) ? $clog2(H_VIS_MAX) : 1,
  localparam int Y_BITS = (V_VIS_MAX > 1) ? $clog2(V_VIS_MAX) : 1
) (
  input  logic                  VGA_clk,
  input  logic                  reset,
  input  logic                  mode_sel,
  output logic [X_BITS-1:0]     pixel_x_req,
  output logic [Y_BITS-1:0]     pixel_y_req,
  output logic                  req_valid,
  input  logic [COLOR_BITS-1:0] pixel_data_in,
  output logic [COLOR_BITS-1:0] rgb_out,
  output logic                  h_sync,
  output logic                  v_sync,
  output logic                  video_on,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  active_mode,
  output logic [15:0]           frame_count
);
  localparam int H_TOT0 = int'(params.h_vis) + int'(params.h_fp) + int'(params.h_sync) + int'(params.h_bp);
  localparam int H_TOT1 = int'(params_alt.h_vis) + int'(params_alt.h_fp) + int'(params_alt.h_sync) + int'(params_alt.h_bp);
  localparam int V_TOT0 = int'(params.v_vis) + int'(params.v_fp) + int'(params.v_sync) + int'(params.v_bp);
  localparam int V_TOT1 = int'(params_alt.v_vis) + int'(params_alt.v_fp) + int'(params_alt.v_sync) + int'(params_alt.v_bp);
  localparam int H_TOT_MAX = (H_TOT0 > H_TOT1) ? H_TOT0 : H_TOT1;
  localparam int V_TOT_MAX = (V_TOT0 > V_TOT1) ? V_TOT0 : V_TOT1;
  localparam int HW = (H_TOT_MAX > 1) ? $clog2(H_TOT_MAX) : 1;
  localparam int VW = (V_TOT_MAX > 1) ? $clog2(V_TOT_MAX) : 1;
  // One spare bit so visible/sync bounds equal to 2^HW still compare correctly
  localparam int HC = HW + 1;
  localparam int VC = VW + 1;

  localparam logic [HC-1:0] H_LAST [2] = '{HC'(H_TOT0 - 1), HC'(H_TOT1 - 1)};
  localparam logic [VC-1:0] V_LAST [2] = '{VC'(V_TOT0 - 1), VC'(V_TOT1 - 1)};
  localparam logic [HC-1:0] H_VIS  [2] = '{HC'(int'(params.h_vis)), HC'(int'(params_alt.h_vis))};
  localparam logic [VC-1:0] V_VIS  [2] = '{VC'(int'(params.v_vis)), VC'(int'(params_alt.v_vis))};
  localparam logic [HC-1:0] H_SS   [2] = '{HC'(int'(params.h_vis) + int'(params.h_fp)),
                                           HC'(int'(params_alt.h_vis) + int'(params_alt.h_fp))};
  localparam logic [HC-1:0] H_SE   [2] = '{HC'(int'(params.h_vis) + int'(params.h_fp) + int'(params.h_sync)),
                                           HC'(int'(params_alt.h_vis) + int'(params_alt.h_fp) + int'(params_alt.h_sync))};
  localparam logic [VC-1:0] V_SS   [2] = '{VC'(int'(params.v_vis) + int'(params.v_fp)),
                                           VC'(int'(params_alt.v_vis) + int'(params_alt.v_fp))};
  localparam logic [VC-1:0] V_SE   [2] = '{VC'(int'(params.v_vis) + int'(params.v_fp) + int'(params.v_sync)),
                                           VC'(int'(params_alt.v_vis) + int'(params_alt.v_fp) + int'(params_alt.v_sync))};
  localparam logic H_AL [2] = '{params.h_sync_active_low, params_alt.h_sync_active_low};
  localparam logic V_AL [2] = '{params.v_sync_active_low, params_alt.v_sync_active_low};

  localparam int F_VIS = 0;
  localparam int F_HS  = 1;
  localparam int F_VS  = 2;
  localparam int F_LS  = 3;
  localparam int F_FS  = 4;
  localparam logic [4:0] IDLE_FLAGS = {1'b0, 1'b0, params.v_sync_active_low, params.h_sync_active_low, 1'b0};

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("vga_scan_engine: LATENCY must be in 1..4");
  end
  if (int'(params.h_vis) > (1 << X_BITS) || int'(params_alt.h_vis) > (1 << X_BITS)) begin : g_bad_width
    $error("vga_scan_engine: visible width exceeds pixel_x_req range");
  end

  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic                  mode_q, mode_d;
  logic [15:0]           fc_q, fc_d;
  logic [4:0]            pipe_q [LATENCY+1];
  logic [4:0]            pipe_d [LATENCY+1];
  logic [COLOR_BITS-1:0] rgb_q, rgb_d;
  logic [HC-1:0]         h_ext;
  logic [VC-1:0]         v_ext;
  logic                  last_h, last_v, in_h_vis, in_v_vis, hs_pulse, vs_pulse;

  always_comb begin
    h_ext    = {1'b0, h_q};
    v_ext    = {1'b0, v_q};
    last_h   = (h_ext == H_LAST[mode_q]);
    last_v   = (v_ext == V_LAST[mode_q]);
    in_h_vis = (h_ext < H_VIS[mode_q]);
    in_v_vis = (v_ext < V_VIS[mode_q]);
    hs_pulse = (h_ext >= H_SS[mode_q]) && (h_ext < H_SE[mode_q]);
    vs_pulse = (v_ext >= V_SS[mode_q]) && (v_ext < V_SE[mode_q]);

    h_d    = last_h ? '0 : h_q + HW'(1);
    v_d    = v_q;
    mode_d = mode_q;
    fc_d   = fc_q;
    if (last_h) begin
      v_d = last_v ? '0 : v_q + VW'(1);
      // mode_sel only matters on the final cycle of a frame
      if (last_v) begin
        mode_d = mode_sel;
        fc_d   = fc_q + 16'd1;
      end
    end

    req_valid   = in_h_vis & in_v_vis;
    pixel_x_req = req_valid ? h_q[X_BITS-1:0] : '0;
    pixel_y_req = req_valid ? v_q[Y_BITS-1:0] : '0;

    // Sync levels are polarity-resolved here so queued pixels keep their mode's polarity
    pipe_d[0]        = 5'b0;
    pipe_d[0][F_VIS] = req_valid;
    pipe_d[0][F_HS]  = hs_pulse ^ H_AL[mode_q];
    pipe_d[0][F_VS]  = vs_pulse ^ V_AL[mode_q];
    pipe_d[0][F_LS]  = (h_q == '0);
    pipe_d[0][F_FS]  = (h_q == '0) && (v_q == '0);
    for (int i = 1; i <= LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    rgb_d = pipe_q[LATENCY-1][F_VIS] ? pixel_data_in : '0;
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      mode_q <= 1'b0;
      fc_q   <= '0;
      rgb_q  <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        pipe_q[i] <= IDLE_FLAGS;
      end
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      mode_q <= mode_d;
      fc_q   <= fc_d;
      rgb_q  <= rgb_d;
      for (int i = 0; i <= LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign rgb_out     = rgb_q;
  assign video_on    = pipe_q[LATENCY][F_VIS];
  assign h_sync      = pipe_q[LATENCY][F_HS];
  assign v_sync      = pipe_q[LATENCY][F_VS];
  assign line_start  = pipe_q[LATENCY][F_LS];
  assign frame_start = pipe_q[LATENCY][F_FS];
  assign active_mode = mode_q;
  assign frame_count = fc_q;
endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench for vga_scan_engine using two tiny timing sets and a latency-2 renderer.
module tb_vga_scan_engine;
  localparam vga_pkg::vga_params_t P0 = '{
    h_vis: 16'd8, h_fp: 16'd2, h_sync: 16'd2, h_bp: 16'd4,
    v_vis: 16'd4, v_fp: 16'd1, v_sync: 16'd1, v_bp: 16'd2,
    h_sync_active_low: 1'b1, v_sync_active_low: 1'b1
  };
  localparam vga_pkg::vga_params_t P1 = '{
    h_vis: 16'd4, h_fp: 16'd1, h_sync: 16'd1, h_bp: 16'd2,
    v_vis: 16'd2, v_fp: 16'd1, v_sync: 16'd1, v_bp: 16'd1,
    h_sync_active_low: 1'b0, v_sync_active_low: 1'b0
  };
  localparam logic [16:0] IDLE = {12'd0, 5'b01100};

  logic        VGA_clk  = 1'b0;
  logic        reset    = 1'b1;
  logic        mode_sel = 1'b0;
  logic        all_ones = 1'b0;
  logic [11:0] pixel_data_in;
  logic [2:0]  pixel_x_req;
  logic [1:0]  pixel_y_req;
  logic        req_valid, h_sync, v_sync, video_on, line_start, frame_start, active_mode;
  logic [11:0] rgb_out;
  logic [15:0] frame_count;
  logic [2:0]  rd1 = 3'd0;
  logic [2:0]  rd2 = 3'd0;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          m_h, m_v;
  logic        m_mode;
  logic [15:0] m_fc;
  logic [16:0] hist [3];
  logic [39:0] obs, expv;

  vga_scan_engine #(
    .params(P0), .params_alt(P1), .COLOR_BITS(12), .LATENCY(2)
  ) dut (
    .VGA_clk(VGA_clk), .reset(reset), .mode_sel(mode_sel),
    .pixel_x_req(pixel_x_req), .pixel_y_req(pixel_y_req), .req_valid(req_valid),
    .pixel_data_in(pixel_data_in), .rgb_out(rgb_out),
    .h_sync(h_sync), .v_sync(v_sync), .video_on(video_on),
    .line_start(line_start), .frame_start(frame_start),
    .active_mode(active_mode), .frame_count(frame_count)
  );

  always #5 VGA_clk = ~VGA_clk;

  // Renderer: returns the requested x two cycles later
  always @(posedge VGA_clk) begin
    rd1 <= pixel_x_req;
    rd2 <= rd1;
  end
  assign pixel_data_in = all_ones ? 12'hFFF : {9'd0, rd2};

  function automatic logic [16:0] exp_out(input logic md, input int h, input int v);
    int hv, vv, hss, hw, vss;
    logic vis, hp, vp, hl, vl;
    logic [11:0] rgb;
    hv  = md ? 4 : 8;
    vv  = md ? 2 : 4;
    hss = md ? 5 : 10;
    hw  = md ? 1 : 2;
    vss = md ? 3 : 5;
    vis = (h < hv) && (v < vv);
    hp  = (h >= hss) && (h < hss + hw);
    vp  = (v == vss);
    hl  = md ? hp : !hp;
    vl  = md ? vp : !vp;
    rgb = !vis ? 12'd0 : (all_ones ? 12'hFFF : 12'(h));
    return {rgb, vis, hl, vl, (h == 0), (h == 0) && (v == 0)};
  endfunction

  function automatic logic [5:0] exp_req(input logic md, input int h, input int v);
    logic vis;
    vis = (h < (md ? 4 : 8)) && (v < (md ? 2 : 4));
    return vis ? {1'b1, 3'(h), 2'(v)} : 6'd0;
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_mode = 1'b0; m_fc = 16'd0; cyc = 0;
    hist[0] = IDLE; hist[1] = IDLE; hist[2] = IDLE;
  endtask

  task automatic step_model();
    int ht, vt;
    logic last;
    ht = m_mode ? 8 : 16;
    vt = m_mode ? 5 : 8;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = exp_out(m_mode, m_h, m_v);
    last = (m_h == ht - 1) && (m_v == vt - 1);
    if (m_h == ht - 1) begin
      m_h = 0;
      m_v = (m_v == vt - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
    if (last) begin
      m_mode = mode_sel;
      m_fc   = m_fc + 16'd1;
    end
    cyc = cyc + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge VGA_clk);
    n_tests++;
    if ({rgb_out, video_on, line_start, frame_start} !== 15'd0) begin
      n_fail++; $display("FAIL reset_idle got=%h exp=0", {rgb_out, video_on, line_start, frame_start});
    end
    n_tests++;
    if ({h_sync, v_sync} !== 2'b11) begin
      n_fail++; $display("FAIL reset_sync got=%b exp=11", {h_sync, v_sync});
    end
    n_tests++;
    if ({active_mode, frame_count} !== 17'd0) begin
      n_fail++; $display("FAIL reset_mode_count got=%h exp=0", {active_mode, frame_count});
    end
    n_tests++;
    if ({req_valid, pixel_x_req, pixel_y_req} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_req got=%b exp=100000", {req_valid, pixel_x_req, pixel_y_req});
    end
    reset = 1'b0;
    model_reset();
    $display("[TB] test_reset done");
  endtask

  task automatic test_first_frame();
    while (cyc < 20) begin
      obs  = {rgb_out, video_on, h_sync, v_sync, line_start, frame_start, req_valid, pixel_x_req, pixel_y_req, active_mode, frame_count};
      expv = {hist[2], exp_req(m_mode, m_h, m_v), m_mode, m_fc};
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL first_frame cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (cyc <= 3) begin
        n_tests++;
        if (frame_start !== (cyc == 3)) begin
          n_fail++; $display("FAIL first_fs cyc=%0d got=%b exp=%b", cyc, frame_start, cyc == 3);
        end
      end
      if (cyc >= 3 && cyc <= 10) begin
        n_tests++;
        if (rgb_out !== 12'(cyc - 3)) begin
          n_fail++; $display("FAIL first_rgb cyc=%0d got=%0d exp=%0d", cyc, rgb_out, cyc - 3);
        end
      end
      step_model();
      @(negedge VGA_clk);
    end
    $display("[TB] test_first_frame done at cyc %0d", cyc);
  endtask

  task automatic test_mode0_freerun();
    int last_fs, pos;
    logic [15:0] fc_fs;
    last_fs = -1;
    fc_fs   = 16'd0;
    while (cyc < 276) begin
      obs  = {rgb_out, video_on, h_sync, v_sync, line_start, frame_start, req_valid, pixel_x_req, pixel_y_req, active_mode, frame_count};
      expv = {hist[2], exp_req(m_mode, m_h, m_v), m_mode, m_fc};
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL freerun cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          n_tests++;
          if (cyc - last_fs != 128) begin n_fail++; $display("FAIL m0_period got=%0d exp=128", cyc - last_fs); end
          n_tests++;
          if (frame_count !== fc_fs + 16'd1) begin
            n_fail++; $display("FAIL m0_fcount got=%0d exp=%0d", frame_count, fc_fs + 16'd1);
          end
        end
        last_fs = cyc;
        fc_fs   = frame_count;
      end
      if (last_fs >= 0) begin
        pos = cyc - last_fs;
        if (pos >= 9 && pos <= 12) begin
          n_tests++;
          if (h_sync !== (pos == 9 || pos == 12)) begin
            n_fail++; $display("FAIL m0_hsync pos=%0d got=%b exp=%b", pos, h_sync, pos == 9 || pos == 12);
          end
        end
        if (pos == 79 || pos == 80 || pos == 95 || pos == 96) begin
          n_tests++;
          if (v_sync !== (pos == 79 || pos == 96)) begin
            n_fail++; $display("FAIL m0_vsync pos=%0d got=%b exp=%b", pos, v_sync, pos == 79 || pos == 96);
          end
        end
      end
      step_model();
      @(negedge VGA_clk);
    end
    $display("[TB] test_mode0_freerun done at cyc %0d", cyc);
  endtask

  task automatic test_mode_switch();
    int last_fs, pos;
    last_fs = -1;
    mode_sel = 1'b1;
    while (cyc < 441) begin
      if (cyc == 400) mode_sel = 1'b0;
      if (cyc == 402) mode_sel = 1'b1;
      obs  = {rgb_out, video_on, h_sync, v_sync, line_start, frame_start, req_valid, pixel_x_req, pixel_y_req, active_mode, frame_count};
      expv = {hist[2], exp_req(m_mode, m_h, m_v), m_mode, m_fc};
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL mode_switch cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      n_tests++;
      if (active_mode !== (cyc >= 384)) begin
        n_fail++; $display("FAIL sw_active cyc=%0d got=%b exp=%b", cyc, active_mode, cyc >= 384);
      end
      if (frame_start === 1'b1 && cyc >= 387) begin
        if (last_fs >= 0) begin
          n_tests++;
          if (cyc - last_fs != 40) begin n_fail++; $display("FAIL m1_period got=%0d exp=40", cyc - last_fs); end
        end
        last_fs = cyc;
      end
      if (last_fs >= 0) begin
        pos = cyc - last_fs;
        if (pos >= 4 && pos <= 6) begin
          n_tests++;
          if (h_sync !== (pos == 5)) begin
            n_fail++; $display("FAIL m1_hsync pos=%0d got=%b exp=%b", pos, h_sync, pos == 5);
          end
        end
      end
      step_model();
      @(negedge VGA_clk);
    end
    $display("[TB] test_mode_switch done at cyc %0d", cyc);
  endtask

  task automatic test_switch_back();
    while (cyc < 481) begin
      if (cyc == 463) mode_sel = 1'b0;
      obs  = {rgb_out, video_on, h_sync, v_sync, line_start, frame_start, req_valid, pixel_x_req, pixel_y_req, active_mode, frame_count};
      expv = {hist[2], exp_req(m_mode, m_h, m_v), m_mode, m_fc};
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL switch_back cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (cyc == 463 || cyc == 464) begin
        n_tests++;
        if (active_mode !== (cyc == 463)) begin
          n_fail++; $display("FAIL back_active cyc=%0d got=%b exp=%b", cyc, active_mode, cyc == 463);
        end
      end
      if (cyc >= 464 && cyc <= 466) begin
        n_tests++;
        if ({h_sync, v_sync} !== {cyc == 464, 1'b0}) begin
          n_fail++; $display("FAIL drain_sync cyc=%0d got=%b exp=%b", cyc, {h_sync, v_sync}, {cyc == 464, 1'b0});
        end
      end
      if (cyc == 467) begin
        n_tests++;
        if ({frame_start, h_sync, v_sync} !== 3'b111) begin
          n_fail++; $display("FAIL back_m0_start got=%b exp=111", {frame_start, h_sync, v_sync});
        end
      end
      step_model();
      @(negedge VGA_clk);
    end
    $display("[TB] test_switch_back done at cyc %0d", cyc);
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    repeat (2) @(negedge VGA_clk);
    reset = 1'b0;
    model_reset();
    while (cyc < 165) begin
      obs  = {rgb_out, video_on, h_sync, v_sync, line_start, frame_start, req_valid, pixel_x_req, pixel_y_req, active_mode, frame_count};
      expv = {hist[2], exp_req(m_mode, m_h, m_v), m_mode, m_fc};
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      step_model();
      @(negedge VGA_clk);
    end
    reset = 1'b1;
    n_tests++;
    if ({pixel_x_req, pixel_y_req, frame_count} !== {3'd5, 2'd2, 16'd1}) begin
      n_fail++; $display("FAIL mid_pos got=%h exp=%h", {pixel_x_req, pixel_y_req, frame_count}, {3'd5, 2'd2, 16'd1});
    end
    model_reset();
    @(negedge VGA_clk);
    reset = 1'b0;
    n_tests++;
    if ({rgb_out, video_on, line_start, frame_start, h_sync, v_sync} !== {12'd0, 3'b000, 2'b11}) begin
      n_fail++; $display("FAIL mid_idle got=%h exp=%h", {rgb_out, video_on, line_start, frame_start, h_sync, v_sync}, {12'd0, 3'b000, 2'b11});
    end
    n_tests++;
    if ({active_mode, frame_count, req_valid, pixel_x_req, pixel_y_req} !== {17'd0, 6'b100000}) begin
      n_fail++; $display("FAIL mid_restart got=%h exp=%h", {active_mode, frame_count, req_valid, pixel_x_req, pixel_y_req}, {17'd0, 6'b100000});
    end
    while (cyc < 12) begin
      obs  = {rgb_out, video_on, h_sync, v_sync, line_start, frame_start, req_valid, pixel_x_req, pixel_y_req, active_mode, frame_count};
      expv = {hist[2], exp_req(m_mode, m_h, m_v), m_mode, m_fc};
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (cyc == 3) begin
        n_tests++;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL post_reset_fs got=%b exp=1", frame_start); end
      end
      step_model();
      @(negedge VGA_clk);
    end
    $display("[TB] test_mid_reset done at cyc %0d", cyc);
  endtask

  task automatic test_blanking();
    int blank_seen;
    blank_seen = 0;
    all_ones = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge VGA_clk);
    reset = 1'b0;
    model_reset();
    while (cyc < 140) begin
      obs  = {rgb_out, video_on, h_sync, v_sync, line_start, frame_start, req_valid, pixel_x_req, pixel_y_req, active_mode, frame_count};
      expv = {hist[2], exp_req(m_mode, m_h, m_v), m_mode, m_fc};
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL blanking cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      n_tests++;
      if (video_on === 1'b0) begin
        blank_seen++;
        if (rgb_out !== 12'd0) begin n_fail++; $display("FAIL blank_rgb cyc=%0d got=%h exp=000", cyc, rgb_out); end
      end else if (rgb_out !== 12'hFFF) begin
        n_fail++; $display("FAIL vis_rgb cyc=%0d got=%h exp=fff", cyc, rgb_out);
      end
      step_model();
      @(negedge VGA_clk);
    end
    n_tests++;
    if (blank_seen != 100) begin n_fail++; $display("FAIL blank_count got=%0d exp=100", blank_seen); end
    all_ones = 1'b0;
    $display("[TB] test_blanking done at cyc %0d", cyc);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_mode0_freerun();
    test_mode_switch();
    test_switch_back();
    test_mid_reset();
    test_blanking();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_scan_engine.md
VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

Interface
REQ-001 SHALL have parameter params, default vga_pkg 640x480@60 set, mode-0 timing record (vga_pkg::vga_params_t).
REQ-002 SHALL have parameter params_alt, default same as params, mode-1 timing record (vga_pkg::vga_params_t).
REQ-003 SHALL have parameter COLOR_BITS, default 12, RGB word width.
REQ-004 SHALL have parameter LATENCY, default 2, renderer read latency in cycles, legal 1..4.
REQ-005 SHALL have port VGA_clk, input, 1, pixel clock; single clock domain.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port mode_sel, input, 1, requested timing set (0=params, 1=params_alt).
REQ-008 SHALL have port pixel_x_req, output, max(pixel_x_bits), renderer x address.
REQ-009 SHALL have port pixel_y_req, output, max(pixel_y_bits), renderer y address.
REQ-010 SHALL have port req_valid, output, 1, address is inside the visible window.
REQ-011 SHALL have port pixel_data_in, input, COLOR_BITS, renderer data, valid LATENCY cycles after its request.
REQ-012 SHALL have port rgb_out, output, COLOR_BITS, blanked colour to DAC pins.
REQ-013 SHALL have ports h_sync and v_sync, output, 1 each, polarity per active mode.
REQ-014 SHALL have port video_on, output, 1, pixel on rgb_out is visible.
REQ-015 SHALL have ports line_start and frame_start, output, 1 each, single-cycle strobes.
REQ-016 SHALL have port active_mode, output, 1, timing set in force.
REQ-017 SHALL have port frame_count, output, 16, completed-frame counter.

Function
REQ-018 SHALL size h/v counters to $clog2 of the larger H_TOTAL/V_TOTAL of both modes (TOTAL = visible+front+sync+back).
REQ-019 SHALL advance h_ctr every cycle, wrap at H_TOTAL-1 of the active mode, and increment v_ctr on wrap, itself wrapping at V_TOTAL-1.
REQ-020 SHALL drive pixel_x_req/pixel_y_req combinationally from h_ctr/v_ctr when inside the visible range, else 0; req_valid = in_h_vis & in_v_vis.
REQ-021 SHALL delay visible, hsync-pulse, vsync-pulse, line_start and frame_start flags through a LATENCY+1 stage shift pipeline.
REQ-022 SHALL register rgb_out = pixel_data_in when the LATENCY-delayed visible flag is set, else 0, so rgb_out and syncs for counter (h,v) appear exactly LATENCY+1 cycles after the request.
REQ-023 SHALL assert the hsync pulse for h in [h_vis+h_fp, h_vis+h_fp+h_sync) and vsync for v in [v_vis+v_fp, v_vis+v_fp+v_sync), inverted when the mode's *_sync_active_low is set.
REQ-024 SHALL pulse line_start aligned with output of h=0 on every line and frame_start aligned with output of (0,0).
REQ-025 SHALL sample mode_sel only on the last cycle of a frame (h=H_TOTAL-1, v=V_TOTAL-1 of the current mode); new totals apply from the next (0,0); mid-frame mode_sel changes SHALL be ignored.
REQ-026 SHALL switch sync polarity with active_mode at the counter (not output) boundary; the pipeline SHALL carry polarity-resolved sync levels so in-flight pixels keep old polarity.
REQ-027 SHALL increment frame_count (mod 2^16) on each frame wrap, in the same cycle active_mode updates.
REQ-028 SHALL elaborate-time error if LATENCY outside 1..4 or a mode's visible width exceeds 2^pixel_x_bits.

Reset
REQ-029 SHALL, on reset high at any clock edge, set h_ctr=v_ctr=0, active_mode=0, frame_count=0, clear all pipeline stages.
REQ-030 SHALL hold during reset: rgb_out=0, video_on=0, line_start=frame_start=0, h_sync/v_sync at mode-0 inactive level.
REQ-031 SHALL resume at counter (0,0) on the first edge after reset deasserts; first frame_start appears LATENCY+1 cycles later.

Verification (mode0: h 8/2/2/4=16, v 4/1/1/2=8, active-low; mode1: h 4/1/1/2=8, v 2/1/1/1=5, active-high; LATENCY=2)
REQ-032 SHALL check: release reset, pixel_data_in=request x -> rgb_out shows 0..7 starting 3 cycles after req (0,0), frame_start at cycle 3.
REQ-033 SHALL check: free-run mode0 -> h_sync low for output h=10..11, v_sync low on lines 5, period 16x8=128 cycles, frame_count +1 per 128.
REQ-034 SHALL check: mode_sel=1 asserted mid-frame -> no change until frame end; next frame 8x5=40 cycles, h_sync high for h=5, active_mode=1.
REQ-035 SHALL check: mode_sel toggled back on last cycle of a mode1 frame -> switch taken, old-polarity syncs drain for 3 cycles.
REQ-036 SHALL check: reset asserted at h=5,v=2 for 1 cycle -> all outputs idle next cycle, restart at (0,0), frame_count=0.
REQ-037 SHALL check: pixel_data_in=all-ones throughout -> rgb_out=0 whenever video_on=0 (porches, sync, vertical blank).
